// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial adder. One full-adder slice and a carry flop are
//                iterated LSB-first over WIDTH cycles under a start/busy/done
//                handshake. Optional subtract mode: SERIAL_ADDER_SUB_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic             s_bit,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_res_sr;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_accept;
    logic               w_last;
    logic               w_b_bit;
    logic               w_sum_bit;
    logic               w_carry_next;
    logic               w_carry_init;
    logic [WIDTH-1:0]   w_res_next;

`ifdef SERIAL_ADDER_SUB_EN
    logic r_sub;

    // Subtraction is a + ~b + 1: invert the b stream and seed the carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sub <= 1'b0;
        end else if (w_accept) begin
            r_sub <= sub;
        end
    end

    assign w_b_bit      = r_b_sr[0] ^ r_sub;
    assign w_carry_init = sub;
`else
    assign w_b_bit      = r_b_sr[0];
    assign w_carry_init = 1'b0;
`endif

    assign w_accept     = (r_state == S_IDLE) && start;
    assign w_last       = (r_state == S_RUN) && (r_cnt == c_LAST);
    assign w_sum_bit    = r_a_sr[0] ^ w_b_bit ^ r_carry;
    assign w_carry_next = (r_a_sr[0] & w_b_bit) | (r_a_sr[0] & r_carry) | (w_b_bit & r_carry);

    generate
        if (WIDTH == 1) begin : g_res_w1
            assign w_res_next = w_sum_bit;
        end else begin : g_res_wn
            assign w_res_next = {w_sum_bit, r_res_sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_res_sr <= '0;
            r_carry  <= w_carry_init;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_res_sr <= w_res_next;
            r_carry  <= w_carry_next;
            r_cnt    <= r_cnt + c_CNT_W'(1);
            // Published results change only when the final bit lands.
            if (w_last) begin
                r_sum  <= w_res_next;
                r_cout <= w_carry_next;
            end
        end
    end

    assign busy  = (r_state == S_RUN);
    assign done  = (r_state == S_DONE);
    assign s_bit = (r_state == S_RUN) & w_sum_bit;
    assign sum   = r_sum;
    assign cout  = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Scoreboard bench for serial_adder; driver pushes expected
//                {cout,sum} per accepted start, monitor checks on busy/done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int W = 4;
`ifdef SERIAL_ADDER_SUB_EN
    localparam logic c_SUB_EN = 1'b1;
`else
    localparam logic c_SUB_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         busy, done, s_bit, cout;
    logic [W-1:0] sum;

    int checks = 0;
    int errors = 0;

    logic [W:0] exp_q[$];
    logic [W:0] held = '0;
    int         bit_idx = 0;
    logic       prev_done = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .s_bit (s_bit),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: {cout,sum} straight from the arithmetic definition.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int unsigned xi = int'(x);
        int unsigned yi = int'(y);
        int unsigned m  = 1 << W;
        if (s) return {(xi >= yi) ? 1'b1 : 1'b0, W'((xi + m - yi) % m)};
        return (W+1)'(xi + yi);
    endfunction

    // Monitor: sample 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            chk("reset_outputs", {27'd0, busy, done, s_bit, cout, sum}, 32'd0);
            exp_q.delete();
            bit_idx   = 0;
            held      = '0;
            prev_done = 1'b0;
        end else begin
            if (busy) begin
                if (exp_q.size() == 0) begin
                    chk("busy_without_op", 32'd1, 32'd0);
                end else if (bit_idx >= W) begin
                    chk("run_too_long", bit_idx, W);
                end else begin
                    chk("s_bit", {31'd0, s_bit}, {31'd0, exp_q[0][bit_idx]});
                    bit_idx++;
                end
            end
            if (done) begin
                chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    held = exp_q.pop_front();
                    chk("run_length", bit_idx, W);
                    chk("result", {27'd0, cout, sum}, {27'd0, held});
                end
                bit_idx = 0;
            end else begin
                chk("result_hold", {27'd0, cout, sum}, {27'd0, held});
            end
            prev_done = done;
        end
    end

    // Called at a falling edge; waits for IDLE, then presents one start.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is);
        int n = 0;
        while ((busy || done) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_timeout", 32'd1, 32'd0);
        start = 1'b1;
        a     = ia;
        b     = ib;
        sub   = is & c_SUB_EN;
        exp_q.push_back(model(ia, ib, is & c_SUB_EN));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(4'd3, 4'd5, 1'b0);
        issue(4'd15, 4'd1, 1'b0);
        issue(4'd0, 4'd0, 1'b0);
        wait_drain();

        // Second start while busy must be ignored.
        issue(4'd9, 4'd9, 1'b0);
        start = 1'b1; a = 4'd1; b = 4'd1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Reset mid-operation abandons it; no done may follow.
        issue(4'd7, 4'd7, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        issue(4'd2, 4'd2, 1'b0);
        wait_drain();

        if (c_SUB_EN) begin
            issue(4'd5, 4'd3, 1'b1);
            issue(4'd3, 4'd5, 1'b1);
            wait_drain();
        end

        for (int i = 0; i < 256; i++) begin
            issue(W'(i >> 4), W'(i & 15), 1'b0);
        end
        wait_drain();

        for (int k = 0; k < 60; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(W'($urandom), W'($urandom), 1'($urandom));
        end
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
